// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with memory wait-state
// timeouts and a sticky trap. Define PERF_CNT_EN to add cycle_cnt/instret_cnt outputs.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned ALUSEL_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [31:0]         instr,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                BrEq,
    input  logic                BrLT,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                IRWEn,
    output logic                PCWEn,
    output logic                PCSel,
    output logic                RegWEn,
    output logic                Asel,
    output logic                Bsel,
    output logic                MemRW,
    output logic                BrUn,
    output logic [2:0]          ImmSel,
    output logic [ALUSEL_W-1:0] ALUSel,
    output logic [1:0]          WBSel,
    output logic [2:0]          state,
    output logic                halted,
`ifdef PERF_CNT_EN
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         instret_cnt,
`endif
    output logic [1:0]          trap_cause
);

    localparam int unsigned     CntW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MEM_TIMEOUT);

    typedef enum logic [2:0] {
        StFetch  = 3'b000,
        StDecode = 3'b001,
        StExec   = 3'b010,
        StMem    = 3'b011,
        StWb     = 3'b100,
        StTrap   = 3'b111
    } state_e;

    localparam logic [4:0] OpcR      = 5'b01100;
    localparam logic [4:0] OpcImm    = 5'b00100;
    localparam logic [4:0] OpcLoad   = 5'b00000;
    localparam logic [4:0] OpcJalr   = 5'b11001;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcAuipc  = 5'b00101;
    localparam logic [4:0] OpcJal    = 5'b11011;

    localparam logic [3:0] AluAdd   = 4'b0000;
    localparam logic [3:0] AluAnd   = 4'b0001;
    localparam logic [3:0] AluOr    = 4'b0010;
    localparam logic [3:0] AluXor   = 4'b0011;
    localparam logic [3:0] AluSrl   = 4'b0100;
    localparam logic [3:0] AluSra   = 4'b0101;
    localparam logic [3:0] AluSll   = 4'b0110;
    localparam logic [3:0] AluSlt   = 4'b0111;
    localparam logic [3:0] AluPassB = 4'b1000;
    localparam logic [3:0] AluSltu  = 4'b1001;
    localparam logic [3:0] AluSub   = 4'b1100;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    state_e          state_q, state_d;
    logic [31:0]     ir_q, ir_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      cause_q, cause_d;
`ifdef PERF_CNT_EN
    logic [63:0]     cycle_q, cycle_d;
    logic [63:0]     instret_q, instret_d;
`endif

    logic [4:0] opc;
    logic [2:0] funct3;
    logic       is_r, is_imm, is_load, is_store, is_branch, is_jal, is_jalr, is_lui, is_auipc;
    logic       is_jump, legal;
    logic       br_taken, br_bad, cnt_expire;
    logic [3:0] f3_alu;
    logic [2:0] sel_imm;
    logic       sel_a, sel_b;
    logic [3:0] sel_alu;
    logic       unused_ir;

    assign opc       = ir_q[6:2];
    assign funct3    = ir_q[14:12];
    assign is_r      = (opc == OpcR);
    assign is_imm    = (opc == OpcImm);
    assign is_load   = (opc == OpcLoad);
    assign is_store  = (opc == OpcStore);
    assign is_branch = (opc == OpcBranch);
    assign is_jal    = (opc == OpcJal);
    assign is_jalr   = (opc == OpcJalr);
    assign is_lui    = (opc == OpcLui);
    assign is_auipc  = (opc == OpcAuipc);
    assign is_jump   = is_jal | is_jalr;
    assign legal     = (ir_q[1:0] == 2'b11) &&
                       (is_r | is_imm | is_load | is_store | is_branch | is_jump |
                        is_lui | is_auipc);
    assign br_bad    = (funct3[2:1] == 2'b01);
    assign unused_ir = ^{ir_q[31], ir_q[29:15]};

    // The wait cycle in flight is the (cnt_q+1)-th; trap when that reaches the limit.
    assign cnt_expire = (32'(cnt_q) + 32'd1) >= MEM_TIMEOUT;

    // ir_q[30] selects sub only for register ops, but sra for both shift-right forms.
    always_comb begin
        unique case (funct3)
            3'b000: f3_alu = (is_r && ir_q[30]) ? AluSub : AluAdd;
            3'b001: f3_alu = AluSll;
            3'b010: f3_alu = AluSlt;
            3'b011: f3_alu = AluSltu;
            3'b100: f3_alu = AluXor;
            3'b101: f3_alu = ir_q[30] ? AluSra : AluSrl;
            3'b110: f3_alu = AluOr;
            3'b111: f3_alu = AluAnd;
        endcase
    end

    always_comb begin
        sel_imm = ImmI;
        sel_a   = 1'b0;
        sel_b   = 1'b0;
        sel_alu = AluAdd;
        if (is_r) begin
            sel_alu = f3_alu;
        end else if (is_imm) begin
            sel_b   = 1'b1;
            sel_alu = f3_alu;
        end else if (is_load || is_jalr) begin
            sel_b = 1'b1;
        end else if (is_store) begin
            sel_imm = ImmS;
            sel_b   = 1'b1;
        end else if (is_branch) begin
            sel_imm = ImmB;
            sel_a   = 1'b1;
            sel_b   = 1'b1;
        end else if (is_jal) begin
            sel_imm = ImmJ;
            sel_a   = 1'b1;
            sel_b   = 1'b1;
        end else if (is_lui) begin
            sel_imm = ImmU;
            sel_b   = 1'b1;
            sel_alu = AluPassB;
        end else if (is_auipc) begin
            sel_imm = ImmU;
            sel_a   = 1'b1;
            sel_b   = 1'b1;
        end
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:         br_taken = BrEq;
            3'b001:         br_taken = !BrEq;
            3'b100, 3'b110: br_taken = BrLT;
            3'b101, 3'b111: br_taken = !BrLT;
            default:        br_taken = 1'b0;
        endcase
    end

    // Next-state logic; the wait counter is zero unless the FSM stays put in FETCH/MEM.
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cnt_d   = '0;
        cause_d = cause_q;
        unique case (state_q)
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end else if (cnt_expire) begin
                    state_d = StTrap;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    cause_d = 2'b01;
                end
            end
            StExec: begin
                if (is_branch) begin
                    if (br_bad) begin
                        state_d = StTrap;
                        cause_d = 2'b01;
                    end else begin
                        state_d = StFetch;
                    end
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                if (dmem_ready) begin
                    state_d = is_store ? StFetch : StWb;
                end else if (cnt_expire) begin
                    state_d = StTrap;
                    cause_d = 2'b11;
                end else begin
                    cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
                end
            end
            StWb:    state_d = StFetch;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    // Outputs decode from state_q/ir_q; only the ready and branch-flag qualifiers are live.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWEn    = 1'b0;
        PCWEn    = 1'b0;
        PCSel    = 1'b0;
        RegWEn   = 1'b0;
        Asel     = 1'b0;
        Bsel     = 1'b0;
        MemRW    = 1'b0;
        BrUn     = 1'b0;
        ImmSel   = 3'b000;
        ALUSel   = '0;
        WBSel    = 2'b00;
        halted   = 1'b0;
        if (state_q == StExec || state_q == StMem || state_q == StWb) begin
            ImmSel      = sel_imm;
            Asel        = sel_a;
            Bsel        = sel_b;
            ALUSel[3:0] = sel_alu;
        end
        unique case (state_q)
            StFetch: begin
                // Gated so requests are low while reset is held, not just after it.
                imem_req = rst_n;
                IRWEn    = rst_n & imem_ready;
            end
            StDecode: begin
                halted = 1'b0;
            end
            StExec: begin
                if (is_branch) begin
                    BrUn  = (funct3[2:1] == 2'b11);
                    PCWEn = !br_bad;
                    PCSel = !br_bad && br_taken;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                MemRW    = is_store;
                PCWEn    = is_store && dmem_ready;
            end
            StWb: begin
                RegWEn = (ir_q[11:7] != 5'd0);
                WBSel  = is_load ? 2'b00 : (is_jump ? 2'b10 : 2'b01);
                PCWEn  = 1'b1;
                PCSel  = is_jump;
            end
            StTrap: begin
                halted = 1'b1;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

`ifdef PERF_CNT_EN
    assign cycle_d     = cycle_q + 64'(state_q != StTrap);
    assign instret_d   = instret_q + 64'(PCWEn);
    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StFetch;
            ir_q      <= '0;
            cnt_q     <= '0;
            cause_q   <= 2'b00;
`ifdef PERF_CNT_EN
            cycle_q   <= '0;
            instret_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
`ifdef PERF_CNT_EN
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
`endif
        end
    end

    assign state      = state_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-instruction model expands each instruction into its
// expected cycle-by-cycle control outputs, which one compare loop checks against the DUT.
module tb_multicycle_ctrl;

    localparam int          TMO  = 4;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req, dmem_req, irwen, pcwen, pcsel, regwen, memrw, brun, asel, bsel;
        logic       halted;
        logic [2:0] imm;
        logic [3:0] alu;
        logic [1:0] wbsel;
        logic [1:0] cause;
    } out_t;

    typedef struct packed {
        logic [31:0] instr;
        logic        ir, dr, eq, lt;
        out_t        o;
    } cyc_t;

    logic        clk, rst_n;
    logic [31:0] instr;
    logic        imem_ready, dmem_ready, br_eq, br_lt;
    logic        imem_req, dmem_req, IRWEn, PCWEn, PCSel, RegWEn, Asel, Bsel, MemRW, BrUn;
    logic [2:0]  ImmSel, state;
    logic [3:0]  ALUSel;
    logic [1:0]  WBSel, trap_cause;
    logic        halted;
`ifdef PERF_CNT_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    cyc_t        q[$];
    int          n_vec, n_err;
    logic [63:0] m_cyc, m_ret;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO), .ALUSEL_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .BrEq       (br_eq),
        .BrLT       (br_lt),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .IRWEn      (IRWEn),
        .PCWEn      (PCWEn),
        .PCSel      (PCSel),
        .RegWEn     (RegWEn),
        .Asel       (Asel),
        .Bsel       (Bsel),
        .MemRW      (MemRW),
        .BrUn       (BrUn),
        .ImmSel     (ImmSel),
        .ALUSel     (ALUSel),
        .WBSel      (WBSel),
        .state      (state),
        .halted     (halted),
`ifdef PERF_CNT_EN
        .cycle_cnt  (cycle_cnt),
        .instret_cnt(instret_cnt),
`endif
        .trap_cause (trap_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): got %h, expected %h", name, n_vec, got, exp);
        end
    endtask

    function automatic out_t dut_out();
        out_t g;
        g.st = state;       g.imem_req = imem_req; g.dmem_req = dmem_req; g.irwen = IRWEn;
        g.pcwen = PCWEn;    g.pcsel = PCSel;       g.regwen = RegWEn;     g.memrw = MemRW;
        g.brun = BrUn;      g.asel = Asel;         g.bsel = Bsel;         g.halted = halted;
        g.imm = ImmSel;     g.alu = ALUSel;        g.wbsel = WBSel;       g.cause = trap_cause;
        return g;
    endfunction

    function automatic void push(input out_t o, input logic [31:0] ins, input logic ir,
                                 input logic dr, input logic eq, input logic lt);
        cyc_t c;
        c.o = o; c.instr = ins; c.ir = ir; c.dr = dr; c.eq = eq; c.lt = lt;
        q.push_back(c);
    endfunction

    function automatic void trap(input logic [1:0] cause, input int n);
        out_t o;
        for (int i = 0; i < n; i++) begin
            o = '0; o.st = 3'd7; o.halted = 1'b1; o.cause = cause;
            push(o, JUNK, 1'b1, 1'b1, 1'b0, 1'b0);
        end
    endfunction

    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? 4'b1100 : 4'b0000;
            3'b001:  return 4'b0110;
            3'b010:  return 4'b0111;
            3'b011:  return 4'b1001;
            3'b100:  return 4'b0011;
            3'b101:  return alt ? 4'b0101 : 4'b0100;
            3'b110:  return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    function automatic out_t exec_sel(input logic [31:0] ins);
        out_t       o = '0;
        logic [2:0] f3 = ins[14:12];
        case (ins[6:2])
            5'b01100: o.alu = alu_of(f3, ins[30]);
            5'b00100: begin o.bsel = 1'b1; o.alu = alu_of(f3, ins[30] && f3 == 3'b101); end
            5'b00000, 5'b11001: o.bsel = 1'b1;
            5'b01000: begin o.imm = 3'b001; o.bsel = 1'b1; end
            5'b11000: begin o.imm = 3'b010; o.asel = 1'b1; o.bsel = 1'b1; end
            5'b11011: begin o.imm = 3'b011; o.asel = 1'b1; o.bsel = 1'b1; end
            5'b01101: begin o.imm = 3'b100; o.bsel = 1'b1; o.alu = 4'b1000; end
            5'b00101: begin o.imm = 3'b100; o.asel = 1'b1; o.bsel = 1'b1; end
            default:  o = '0;
        endcase
        return o;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'b000:         return eq;
            3'b001:         return !eq;
            3'b100, 3'b110: return lt;
            default:        return !lt;
        endcase
    endfunction

    // Expand one instruction into its expected cycles. Readies for the other memory are
    // held high throughout to show they are ignored.
    function automatic void gen(input logic [31:0] ins, input int iwait, input int dwait,
                                input logic eq, input logic lt);
        out_t       o, sel;
        logic [4:0] opc = ins[6:2];
        logic [2:0] f3  = ins[14:12];
        logic       ld  = (opc == 5'b00000);
        logic       sto = (opc == 5'b01000);
        logic       jmp = (opc == 5'b11011) || (opc == 5'b11001);
        logic       ok  = (ins[1:0] == 2'b11) && (opc inside {5'b01100, 5'b00100, 5'b00000,
                          5'b11001, 5'b01000, 5'b11000, 5'b01101, 5'b00101, 5'b11011});
        for (int i = 0; i < iwait; i++) begin
            o = '0; o.imem_req = 1'b1;
            push(o, JUNK, 1'b0, 1'b1, eq, lt);
            if (i + 1 == TMO) begin trap(2'b10, 3); return; end
        end
        o = '0; o.imem_req = 1'b1; o.irwen = 1'b1;
        push(o, ins, 1'b1, 1'b1, eq, lt);
        o = '0; o.st = 3'd1;
        push(o, JUNK, 1'b1, 1'b1, eq, lt);
        if (!ok) begin trap(2'b01, 3); return; end
        sel = exec_sel(ins);
        o = sel; o.st = 3'd2;
        if (opc == 5'b11000) begin
            o.brun = (f3[2:1] == 2'b11);
            if (f3[2:1] == 2'b01) begin
                push(o, JUNK, 1'b1, 1'b1, eq, lt);
                trap(2'b01, 3);
                return;
            end
            o.pcwen = 1'b1; o.pcsel = taken(f3, eq, lt);
            push(o, JUNK, 1'b1, 1'b1, eq, lt);
            return;
        end
        push(o, JUNK, 1'b1, 1'b1, eq, lt);
        if (ld || sto) begin
            for (int i = 0; i < dwait; i++) begin
                o = sel; o.st = 3'd3; o.dmem_req = 1'b1; o.memrw = sto;
                push(o, JUNK, 1'b1, 1'b0, eq, lt);
                if (i + 1 == TMO) begin trap(2'b11, 3); return; end
            end
            o = sel; o.st = 3'd3; o.dmem_req = 1'b1; o.memrw = sto; o.pcwen = sto;
            push(o, JUNK, 1'b1, 1'b1, eq, lt);
            if (sto) return;
        end
        o = sel; o.st = 3'd4; o.regwen = (ins[11:7] != 5'd0);
        o.wbsel = ld ? 2'b00 : (jmp ? 2'b10 : 2'b01);
        o.pcwen = 1'b1; o.pcsel = jmp;
        push(o, JUNK, 1'b1, 1'b1, eq, lt);
    endfunction

    task automatic run_queue();
        cyc_t c;
        while (q.size() != 0) begin
            c = q.pop_front();
            instr = c.instr; imem_ready = c.ir; dmem_ready = c.dr; br_eq = c.eq; br_lt = c.lt;
            #1;
            check("cycle_outputs", 64'(dut_out()), 64'(c.o));
`ifdef PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, m_cyc);
            check("instret_cnt", instret_cnt, m_ret);
`endif
            if (c.o.st != 3'd7) m_cyc++;
            if (c.o.pcwen) m_ret++;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; instr = '0;
        br_eq = 1'b0; br_lt = 1'b0;
        #1;
        check("reset_outputs", 64'(dut_out()), 64'd0);
`ifdef PERF_CNT_EN
        check("reset_cycle_cnt", cycle_cnt, 64'd0);
        check("reset_instret_cnt", instret_cnt, 64'd0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; m_cyc = '0; m_ret = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        out_t lit;
        n_vec = 0; n_err = 0; m_cyc = '0; m_ret = '0;
        rst_n = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0;
        br_eq = 1'b0; br_lt = 1'b0;
        #2;
        do_reset();

        // addi x1,x0,5: FETCH, DECODE, EXEC, WB
        gen(32'h0050_0093, 0, 0, 1'b0, 1'b0);
        check("addi_cpi_model", 64'(q.size()), 64'd4);
        lit = '0; lit.st = 3'd4; lit.regwen = 1'b1; lit.wbsel = 2'b01; lit.bsel = 1'b1;
        lit.pcwen = 1'b1;
        check("addi_wb_model", 64'(q[3].o), 64'(lit));
        run_queue();

        // bltu taken: three cycles, no WB
        gen(32'h0020_E063, 0, 0, 1'b0, 1'b1);
        check("bltu_cpi_model", 64'(q.size()), 64'd3);
        lit = '0; lit.st = 3'd2; lit.brun = 1'b1; lit.pcsel = 1'b1; lit.pcwen = 1'b1;
        lit.asel = 1'b1; lit.bsel = 1'b1; lit.imm = 3'b010;
        check("bltu_exec_model", 64'(q[2].o), 64'(lit));
        run_queue();

        // lw with three dmem wait cycles: CPI 8
        gen(32'h0000_A503, 0, 3, 1'b0, 1'b0);
        check("lw_cpi_model", 64'(q.size()), 64'd8);
        run_queue();

        gen(32'h0020_81B3, 0, 0, 1'b0, 1'b0);   // add
        gen(32'h4020_8233, 1, 0, 1'b0, 1'b0);   // sub, one imem wait
        gen(32'h0020_C2B3, 0, 0, 1'b0, 1'b0);   // xor
        gen(32'h0020_B333, 2, 0, 1'b0, 1'b0);   // sltu, two imem waits
        gen(32'h4020_D393, 0, 0, 1'b0, 1'b0);   // srai
        gen(32'h1234_5437, 0, 0, 1'b0, 1'b0);   // lui
        gen(32'h0000_1497, 0, 0, 1'b0, 1'b0);   // auipc
        gen(32'h0080_00EF, 0, 0, 1'b0, 1'b0);   // jal x1
        gen(32'h0000_8067, 0, 0, 1'b0, 1'b0);   // jalr x0
        gen(32'h0020_8063, 0, 0, 1'b1, 1'b0);   // beq taken
        gen(32'h0020_9063, 0, 0, 1'b1, 1'b0);   // bne not taken
        gen(32'h0020_C063, 0, 0, 1'b0, 1'b0);   // blt not taken
        gen(32'h0020_D063, 0, 0, 1'b0, 1'b0);   // bge taken
        gen(32'h0020_F063, 0, 0, 1'b0, 1'b1);   // bgeu not taken
        gen(32'h0020_A023, 0, 1, 1'b0, 1'b0);   // sw, one dmem wait
        gen(32'h0000_A503, 0, 0, 1'b0, 1'b0);   // lw, no wait
        gen(32'h0050_0013, 0, 0, 1'b0, 1'b0);   // addi x0: no register write
        run_queue();

        // Illegal opcode traps from DECODE
        gen(32'h0000_007F, 0, 0, 1'b0, 1'b0);
        run_queue();
        do_reset();

        // Branch funct3 010 traps from EXEC
        gen(32'h0020_A063, 0, 0, 1'b0, 1'b0);
        run_queue();
        do_reset();

        // instr[1:0] != 11 is illegal
        gen(32'h0050_0091, 0, 0, 1'b0, 1'b0);
        run_queue();
        do_reset();

        // imem timeout after four FETCH cycles
        gen(32'h0050_0093, 10, 0, 1'b0, 1'b0);
        check("imem_timeout_model", 64'(q.size()), 64'd7);
        run_queue();
        do_reset();

        // dmem timeout
        gen(32'h0000_A503, 0, 10, 1'b0, 1'b0);
        run_queue();
        do_reset();

        // Reset asserted while a store waits in MEM
        gen(32'h0020_A023, 0, 3, 1'b0, 1'b0);
        void'(q.pop_back());
        run_queue();
        #1;
        check("store_mem_state", 64'(state), 64'd3);
        check("store_mem_dmem_req", 64'(dmem_req), 64'd1);
        check("store_mem_memrw", 64'(MemRW), 64'd1);
        #1;
        do_reset();

        gen(32'h0050_0093, 0, 0, 1'b0, 1'b0);
        run_queue();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
